// File: rtl/insmem_loader.sv
// Instruction-memory loader: packs a little-endian byte stream into 16-bit words and owns the write port while loading.
// Latency: 2 + WRITE_HOLD cycles per word with continuous bytes; idle insmem_pc is a combinational pass-through of cpu_pc.
// Backpressure: byte_ready is high only in LO/HI; bytes offered at other times are left with the source.
module insmem_loader #(
    parameter int PC_BITS    = 6,
    parameter int WORD_COUNT = 2 ** (PC_BITS - 1),
    parameter int WRITE_HOLD = 2
) (
    input  logic               clka,
    input  logic               reset,
    input  logic               load_start,
    input  logic [PC_BITS-2:0] load_len,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    input  logic [PC_BITS-1:0] cpu_pc,
    output logic               cpu_stall,
    output logic               insmem_we,
    output logic [PC_BITS-1:0] insmem_pc,
    output logic [15:0]        insmem_din,
    output logic               load_busy,
    output logic               load_done
);

    localparam int IW = PC_BITS - 1;
    localparam int HW = (WRITE_HOLD > 1) ? $clog2(WRITE_HOLD) : 1;
    // Index of the last word when load_len is 0 (i.e. a full-size program)
    localparam logic [IW-1:0] LAST_MAX  = IW'(WORD_COUNT - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(WRITE_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        WRITE,
        DONE
    } state_t;

    state_t         state;
    logic [IW-1:0]  word_idx;
    logic [IW-1:0]  last_idx;
    logic [HW-1:0]  hold_cnt;

    // While busy the loader drives the word address; otherwise the CPU fetch address passes straight through.
    assign insmem_pc = load_busy ? {word_idx, 1'b0} : cpu_pc;

    // Load sequencer: byte assembly, held write strobe, and all registered status outputs.
    always_ff @(posedge clka) begin
        if (reset) begin
            state      <= IDLE;
            word_idx   <= '0;
            last_idx   <= '0;
            hold_cnt   <= '0;
            byte_ready <= 1'b0;
            cpu_stall  <= 1'b0;
            load_busy  <= 1'b0;
            load_done  <= 1'b0;
            insmem_we  <= 1'b0;
            insmem_din <= '0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        // Storing count-1 keeps the comparison within word_idx width
                        last_idx   <= (load_len == '0) ? LAST_MAX : load_len - 1'b1;
                        word_idx   <= '0;
                        state      <= LO;
                        byte_ready <= 1'b1;
                        load_busy  <= 1'b1;
                        cpu_stall  <= 1'b1;
                    end
                end
                LO: begin
                    if (byte_valid && byte_ready) begin
                        insmem_din[7:0] <= byte_in;
                        state           <= HI;
                    end
                end
                HI: begin
                    if (byte_valid && byte_ready) begin
                        insmem_din[15:8] <= byte_in;
                        state            <= WRITE;
                        byte_ready       <= 1'b0;
                        insmem_we        <= 1'b1;
                        hold_cnt         <= HOLD_INIT;
                    end
                end
                WRITE: begin
                    if (hold_cnt == '0) begin
                        insmem_we <= 1'b0;
                        if (word_idx == last_idx) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                        end else begin
                            word_idx   <= word_idx + 1'b1;
                            state      <= LO;
                            byte_ready <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    load_busy <= 1'b0;
                    cpu_stall <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_insmem_loader.sv
// Directed bench for insmem_loader (PC_BITS=6, WRITE_HOLD=2).
// Inputs change 1 ns after the rising edge; DUT outputs are sampled on the falling edge.
// A write monitor records every we-high window (address, data, length) for the directed steps to compare.
module tb_insmem_loader;

    logic        clka = 1'b0;
    logic        reset;
    logic        load_start;
    logic [4:0]  load_len;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [5:0]  cpu_pc;
    logic        cpu_stall;
    logic        insmem_we;
    logic [5:0]  insmem_pc;
    logic [15:0] insmem_din;
    logic        load_busy;
    logic        load_done;

    always #5 clka = ~clka;

    insmem_loader #(.PC_BITS(6), .WORD_COUNT(32), .WRITE_HOLD(2)) dut (
        .clka      (clka),
        .reset     (reset),
        .load_start(load_start),
        .load_len  (load_len),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .cpu_pc    (cpu_pc),
        .cpu_stall (cpu_stall),
        .insmem_we (insmem_we),
        .insmem_pc (insmem_pc),
        .insmem_din(insmem_din),
        .load_busy (load_busy),
        .load_done (load_done)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int start_cyc = 0;

    logic [5:0]  wr_pc[$];
    logic [15:0] wr_din[$];
    int          wr_len[$];
    int          stable_viol = 0;
    int          gap_viol    = 0;
    int          done_cnt    = 0;
    int          done_cyc    = 0;
    int          bytes_taken = 0;
    logic        prev_we  = 1'b0;
    logic [5:0]  last_pc  = '0;
    logic [15:0] last_din = '0;
    int          low_run  = 0;
    logic [15:0] mem_model [0:31];
    logic [7:0]  src_q[$];

    always @(posedge clka) cyc <= cyc + 1;

    // Write/handshake monitor, sampled mid-cycle
    always @(negedge clka) begin
        if (load_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (byte_valid && byte_ready) bytes_taken++;
        if (insmem_we) begin
            if (!prev_we) begin
                if (wr_pc.size() > 0 && low_run < 2) gap_viol++;
                wr_pc.push_back(insmem_pc);
                wr_din.push_back(insmem_din);
                wr_len.push_back(1);
            end else begin
                if (insmem_pc !== last_pc || insmem_din !== last_din) stable_viol++;
                wr_len[wr_len.size()-1]++;
            end
            mem_model[insmem_pc[5:1]] = insmem_din;
            low_run = 0;
        end else begin
            low_run++;
        end
        prev_we  = insmem_we;
        last_pc  = insmem_pc;
        last_din = insmem_din;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wr_pc.delete();
        wr_din.delete();
        wr_len.delete();
        stable_viol = 0;
        gap_viol    = 0;
        done_cnt    = 0;
        bytes_taken = 0;
    endtask

    // Pulse load_start and stream src_q; optionally re-pulse load_start once idx reaches pulse_idx.
    task automatic do_load(input logic [4:0] len, input bit toggle, input int pulse_idx);
        int idx    = 0;
        int guard  = 0;
        bit hs;
        bit phase  = 1'b1;
        bit pulsed = 1'b0;
        @(posedge clka); #1;
        load_start = 1'b1;
        load_len   = len;
        start_cyc  = cyc;
        byte_valid = 1'b1;
        byte_in    = src_q[0];
        while (idx < src_q.size() && guard < 2000) begin
            @(negedge clka);
            hs = byte_valid && byte_ready;
            @(posedge clka); #1;
            guard++;
            load_start = 1'b0;
            if (hs) idx++;
            if (pulse_idx >= 0 && idx == pulse_idx && !pulsed) begin
                load_start = 1'b1;
                load_len   = 5'd1;
                pulsed     = 1'b1;
            end
            phase      = toggle ? ~phase : 1'b1;
            byte_valid = phase && (idx < src_q.size());
            if (byte_valid) byte_in = src_q[idx];
            else            byte_in = 8'hEE;
        end
        load_start = 1'b0;
        byte_valid = 1'b0;
        check("feed_complete", idx, src_q.size());
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt < 1 && n < budget) begin
            @(posedge clka); #1;
            n++;
        end
        check("done_seen", (done_cnt >= 1) ? 1 : 0, 1);
    endtask

    // Common checks for the three-word program 1234/5678/9ABC
    task automatic check_three(input string tag, input bit check_lat);
        logic [15:0] exp_din [0:2];
        exp_din[0] = 16'h1234;
        exp_din[1] = 16'h5678;
        exp_din[2] = 16'h9ABC;
        check({tag, "_nwrites"}, wr_pc.size(), 3);
        for (int k = 0; k < 3 && k < wr_pc.size(); k++) begin
            check({tag, "_pc"},  wr_pc[k],  k * 2);
            check({tag, "_din"}, wr_din[k], exp_din[k]);
            check({tag, "_len"}, wr_len[k], 2);
        end
        check({tag, "_stable"}, stable_viol, 0);
        check({tag, "_gap"},    gap_viol, 0);
        check({tag, "_ndone"},  done_cnt, 1);
        check({tag, "_bytes"},  bytes_taken, 6);
        // 14 cycles counting both the load_start cycle and the done cycle = 13 edges apart
        if (check_lat) check({tag, "_latency"}, done_cyc - start_cyc, 13);
        check({tag, "_stall"},  cpu_stall, 1'b0);
        check({tag, "_busy"},   load_busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        load_len   = '0;
        byte_in    = '0;
        byte_valid = 1'b0;
        cpu_pc     = 6'h0A;

        // Reset state
        repeat (3) @(posedge clka);
        @(negedge clka);
        check("rst_we",    insmem_we,  1'b0);
        check("rst_din",   insmem_din, 16'h0000);
        check("rst_ready", byte_ready, 1'b0);
        check("rst_stall", cpu_stall,  1'b0);
        check("rst_busy",  load_busy,  1'b0);
        check("rst_done",  load_done,  1'b0);
        reset = 1'b0;

        // Idle pass-through
        @(negedge clka);
        check("idle_pc",    insmem_pc, 6'h0A);
        check("idle_we",    insmem_we, 1'b0);
        check("idle_stall", cpu_stall, 1'b0);
        check("idle_ready", byte_ready, 1'b0);
        cpu_pc = 6'h15;
        #1;
        check("idle_pc_comb", insmem_pc, 6'h15);

        // Three words, continuous bytes
        src_q = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
        clear_mon();
        do_load(5'd3, 1'b0, -1);
        wait_done(100);
        repeat (4) @(posedge clka);
        #1;
        check_three("cont", 1'b1);
        check("cont_pc_idle", insmem_pc, 6'h15);

        // Same program, byte_valid toggling every other cycle
        clear_mon();
        do_load(5'd3, 1'b1, -1);
        wait_done(200);
        repeat (4) @(posedge clka);
        #1;
        check_three("tog", 1'b0);

        // load_start re-pulsed mid-load (with load_len=1) must be ignored
        clear_mon();
        do_load(5'd3, 1'b0, 3);
        wait_done(100);
        repeat (4) @(posedge clka);
        #1;
        check_three("repulse", 1'b1);

        // load_len=0 loads the full 32 words
        src_q.delete();
        for (int i = 0; i < 64; i++) src_q.push_back(8'(i));
        clear_mon();
        do_load(5'd0, 1'b0, -1);
        wait_done(400);
        repeat (10) @(posedge clka);
        #1;
        check("full_nwrites", wr_pc.size(), 32);
        for (int k = 0; k < 32 && k < wr_pc.size(); k++) begin
            check("full_pc",  wr_pc[k],  k * 2);
            check("full_din", wr_din[k], {8'(2 * k + 1), 8'(2 * k)});
        end
        if (wr_pc.size() > 0) check("full_last_pc", wr_pc[wr_pc.size()-1], 6'h3E);
        check("full_ndone",  done_cnt, 1);
        check("full_stable", stable_viol, 0);
        check("full_latency", done_cyc - start_cyc, 1 + 32 * 4);

        // Reset during the WRITE of word 1
        src_q = '{8'h34, 8'h12, 8'h78, 8'h56};
        clear_mon();
        do_load(5'd3, 1'b0, -1);
        @(negedge clka);
        check("mid_we_pre", insmem_we, 1'b1);
        check("mid_pc_pre", insmem_pc, 6'h02);
        reset = 1'b1;
        @(negedge clka);
        check("mid_we",    insmem_we,  1'b0);
        check("mid_stall", cpu_stall,  1'b0);
        check("mid_busy",  load_busy,  1'b0);
        check("mid_ready", byte_ready, 1'b0);
        check("mid_pc",    insmem_pc,  6'h15);
        check("mid_din",   insmem_din, 16'h0000);
        @(posedge clka); #1;
        reset = 1'b0;
        check("mid_word0", mem_model[0], 16'h1234);
        check("mid_ndone", done_cnt, 0);

        // Fresh one-word load after the abort starts at pc 0
        src_q = '{8'h11, 8'h22};
        clear_mon();
        do_load(5'd1, 1'b0, -1);
        wait_done(100);
        repeat (4) @(posedge clka);
        #1;
        check("after_nwrites", wr_pc.size(), 1);
        if (wr_pc.size() > 0) begin
            check("after_pc",  wr_pc[0],  6'h00);
            check("after_din", wr_din[0], 16'h2211);
            check("after_len", wr_len[0], 2);
        end
        check("after_latency", done_cyc - start_cyc, 1 + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/insmem_loader.md
# insmem_loader

Sequencer and port arbiter for the instruction memory. Accepts a program as a byte stream with a valid/ready handshake and packs bytes little-endian into 16-bit words. Drives the instruction memory write port, holding address, data and write enable stable for a programmable number of cycles per word. While loading, it owns the instruction memory address and stalls the CPU fetch; when idle, it passes the CPU program counter through unchanged.

## Interface
Parameters:
- PC_BITS, 6, width of the byte-addressed PC; words are addressed by PC[PC_BITS-1:1]
- WORD_COUNT, 2**(PC_BITS-1), maximum number of words in a program
- WRITE_HOLD, 2, cycles that insmem_we/pc/din are held per word write (≥1)

Ports:
- clka  in  1  single system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- load_start  in  1  one-cycle request to begin a load; sampled only in IDLE
- load_len  in  PC_BITS-1  word count, sampled with load_start; 0 means WORD_COUNT
- byte_in  in  8  program byte
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  loader will accept a byte this cycle
- cpu_pc  in  PC_BITS  CPU fetch address
- cpu_stall  out  1  CPU must hold its PC; high whenever a load is in progress
- insmem_we  out  1  to instruction memory write enable
- insmem_pc  out  PC_BITS  to instruction memory address
- insmem_din  out  16  to instruction memory write data
- load_busy  out  1  high from the cycle after load_start until DONE is exited
- load_done  out  1  one-cycle pulse when the last word write completes

## Operation
- States: IDLE, LO, HI, WRITE, DONE.
- IDLE:
  - byte_ready=0; insmem_we=0.
  - insmem_pc follows cpu_pc combinationally; this is the only combinational path.
  - On load_start: latch the word count (0→WORD_COUNT), set word_idx=0, go to LO.
- LO:
  - byte_ready=1.
  - On byte_valid&byte_ready: din[7:0]=byte_in, go to HI.
- HI:
  - byte_ready=1.
  - On handshake: din[15:8]=byte_in, go to WRITE with hold counter = WRITE_HOLD-1.
- WRITE:
  - insmem_we=1, insmem_pc={word_idx,1'b0}, insmem_din stable.
  - Hold counter decrements each cycle. At 0:
    - If word_idx == count-1, go to DONE.
    - Otherwise word_idx+1, go to LO.
- DONE:
  - insmem_we=0, load_done=1 for exactly one cycle, then go to IDLE.
- Bytes arriving with byte_valid while byte_ready=0 are not consumed; the source must hold them.
- While busy (LO/HI/WRITE/DONE), insmem_pc = {word_idx,1'b0} and cpu_pc is ignored.
- word_idx is PC_BITS-1 bits wide. Count ≤ WORD_COUNT, so word_idx never wraps. insmem_pc LSB is always 0 during a load.
- load_start while not in IDLE is ignored.
- Reset values: state=IDLE, byte_ready=0, cpu_stall=0, load_busy=0, load_done=0, insmem_we=0, insmem_din=0, word_idx=0. insmem_pc then equals cpu_pc.
- Reset mid-load: abort on that edge. A partially assembled word is discarded and insmem_we drops. Words already written remain in memory.

## Timing
- Registered outputs: byte_ready, insmem_we, insmem_din, load_busy, cpu_stall, load_done, and insmem_pc while busy.
- load_start at edge N: state=LO and byte_ready=1, cpu_stall=1, load_busy=1 from N+1.
- With byte_valid held high, each word takes 2 + WRITE_HOLD cycles.
- A full load with continuous bytes takes 1 + count·(2+WRITE_HOLD) + 1 cycles from load_start to load_done.
- insmem_we rises in the cycle after the HI handshake and stays high for exactly WRITE_HOLD consecutive cycles. Address and data do not change during this window.
- Between words, insmem_we is low for at least 2 cycles.
- cpu_stall falls in the same cycle load_done is high plus one, i.e. the first IDLE cycle.

## Test plan
- Reset, then idle with cpu_pc=6'h0A → insmem_pc=6'h0A, insmem_we=0, cpu_stall=0, byte_ready=0.
- load_len=3; bytes 34,12,78,56,BC,9A with continuous valid and WRITE_HOLD=2 → writes 16'h1234@pc 0, 16'h5678@pc 2, 16'h9ABC@pc 4. Each write has we high for exactly 2 cycles. load_done pulses once, 14 cycles after load_start.
- Same load with byte_valid toggling every other cycle → identical writes; no byte is consumed while byte_valid=0.
- load_len=0 → exactly 32 writes, with the last at insmem_pc=6'h3E; load_done follows, and there are no further writes.
- load_start pulsed again mid-load → ignored; the word count and address are unchanged.
- reset asserted in WRITE of word 1 → the next cycle shows insmem_we=0, IDLE, cpu_stall=0. Word 0 is retained; a new load then starts at pc 0.
